// File: rtl/alu_issue_unit.sv
// Issue front-end for the 8-bit combinational ALU: accepts a request, presents
// register-file operands to the ALU, writes the result back and returns a response.
module alu_issue_unit #(
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [REG_ADDR_W-1:0] req_rd,
    input  logic [REG_ADDR_W-1:0] req_rs1,
    input  logic [REG_ADDR_W-1:0] req_rs2,
    input  logic [7:0]            req_imm,
    output logic [3:0]            alu_op,
    output logic [7:0]            alu_operand1,
    output logic [7:0]            alu_operand2,
    input  logic [7:0]            alu_result,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [7:0]            resp_data,
    output logic [REG_ADDR_W-1:0] resp_rd,
    output logic                  resp_err,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [7:0]            dbg_data
);
    localparam int DEPTH = 2 ** REG_ADDR_W;

    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic [7:0]              rf_q [DEPTH];
    logic [REG_ADDR_W-1:0]   rd_q;
    logic [7:0]              imm_q;
    logic [3:0]              alu_op_q;
    logic [7:0]              alu_operand1_q;
    logic [7:0]              alu_operand2_q;
    logic                    req_ready_q;
    logic                    resp_valid_q;
    logic [7:0]              resp_data_q;
    logic [REG_ADDR_W-1:0]   resp_rd_q;
    logic                    resp_err_q;

    logic                    exec_err_d;
    logic [7:0]              exec_data_d;

    // Operands are captured at accept time, so the ALU sees stable registers
    // for the whole EXEC cycle; no write-back can land between accept and EXEC.
    always_comb begin
        exec_err_d  = 1'b0;
        exec_data_d = 8'd0;
        if ((alu_op_q >= 4'd9) && (alu_op_q <= 4'd14)) begin
            exec_err_d = 1'b1;
        end else if (((alu_op_q == OP_DIV) || (alu_op_q == OP_MOD)) && (alu_operand2_q == 8'd0)) begin
            exec_err_d = 1'b1;
        end
        if (!exec_err_d) begin
            exec_data_d = (alu_op_q == OP_LDI) ? imm_q : alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rd_q           <= '0;
            imm_q          <= 8'd0;
            alu_op_q       <= 4'd0;
            alu_operand1_q <= 8'd0;
            alu_operand2_q <= 8'd0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= 8'd0;
            resp_rd_q      <= '0;
            resp_err_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= 8'd0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        alu_op_q       <= req_op;
                        alu_operand1_q <= rf_q[req_rs1];
                        alu_operand2_q <= rf_q[req_rs2];
                        rd_q           <= req_rd;
                        imm_q          <= req_imm;
                        req_ready_q    <= 1'b0;
                        state_q        <= EXEC;
                    end
                end
                EXEC: begin
                    if (!exec_err_d) begin
                        rf_q[rd_q] <= exec_data_d;
                    end
                    resp_data_q  <= exec_data_d;
                    resp_rd_q    <= rd_q;
                    resp_err_q   <= exec_err_d;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_rd      = resp_rd_q;
    assign resp_err     = resp_err_q;
    assign alu_op       = alu_op_q;
    assign alu_operand1 = alu_operand1_q;
    assign alu_operand2 = alu_operand2_q;
    assign dbg_data     = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: directed requests push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_alu_issue_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [1:0] req_rd, req_rs1, req_rs2;
    logic [7:0] req_imm;
    logic [3:0] alu_op;
    logic [7:0] alu_operand1, alu_operand2, alu_result;
    logic       resp_valid, resp_ready;
    logic [7:0] resp_data;
    logic [1:0] resp_rd;
    logic       resp_err;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        logic [1:0] rd;
        logic       err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_issue_unit #(.REG_ADDR_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .alu_op(alu_op), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_err(resp_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // The team's combinational ALU, as seen by the unit.
    always_comb begin
        alu_result = 8'd0;
        case (alu_op)
            4'd0: alu_result = alu_operand1 + alu_operand2;
            4'd1: alu_result = alu_operand1 - alu_operand2;
            4'd2: alu_result = alu_operand1 * alu_operand2;
            4'd3: alu_result = (alu_operand2 == 8'd0) ? 8'd0 : alu_operand1 / alu_operand2;
            4'd4: alu_result = (alu_operand2 == 8'd0) ? 8'd0 : alu_operand1 % alu_operand2;
            4'd5: alu_result = ~alu_operand1;
            4'd6: alu_result = alu_operand1 & alu_operand2;
            4'd7: alu_result = alu_operand1 | alu_operand2;
            4'd8: alu_result = alu_operand1 ^ alu_operand2;
            default: alu_result = 8'd0;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s value=%0d", name, act);
        end
    endtask

    // Monitor: one pop per response handshake.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual data=%0d rd=%0d err=%0d required=no response",
                         resp_data, resp_rd, resp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("resp rd=%0d data=%0d err=%0d (expect rd=%0d data=%0d err=%0d)",
                         resp_rd, resp_data, resp_err, e.rd, e.data, e.err);
                chk("resp_data", int'(resp_data), int'(e.data));
                chk("resp_rd", int'(resp_rd), int'(e.rd));
                chk("resp_err", int'(resp_err), int'(e.err));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [7:0] imm,
                         input logic [7:0] exp_d, input logic exp_e, input bit hold);
        exp_t e;
        e.data = exp_d;
        e.rd   = rd;
        e.err  = exp_e;
        sb.push_back(e);
        @(negedge clk);
        chk("req_ready_idle", int'(req_ready), 1);
        req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("req_ready_exec", int'(req_ready), 0);
        chk("resp_valid_exec", int'(resp_valid), 0);
        @(posedge clk); #1;
        chk("resp_valid_latency", int'(resp_valid), 1);
        if (!hold) begin
            @(posedge clk); #1;
            chk("resp_valid_drop", int'(resp_valid), 0);
            chk("req_ready_back", int'(req_ready), 1);
        end
    endtask

    task automatic dbg(input logic [1:0] a, input int exp);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg_r%0d", a), int'(dbg_data), exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_rd = 2'd0; req_rs1 = 2'd0;
        req_rs2 = 2'd0; req_imm = 8'd0; resp_ready = 1'b1; dbg_addr = 2'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_data", int'(resp_data), 0);
        chk("rst_resp_rd", int'(resp_rd), 0);
        chk("rst_resp_err", int'(resp_err), 0);
        chk("rst_alu_op", int'(alu_op), 0);
        chk("rst_alu_operand1", int'(alu_operand1), 0);
        chk("rst_alu_operand2", int'(alu_operand2), 0);
        for (int i = 0; i < 4; i++) dbg(2'(i), 0);

        // LDI / ADD with wrap-around
        issue(4'd15, 2'd1, 2'd0, 2'd0, 8'd200, 8'd200, 1'b0, 1'b0);
        issue(4'd15, 2'd2, 2'd0, 2'd0, 8'd100, 8'd100, 1'b0, 1'b0);
        issue(4'd0,  2'd3, 2'd1, 2'd2, 8'd0,   8'd44,  1'b0, 1'b0);
        dbg(2'd3, 44);

        // Arithmetic / logic with r1=200, r2=100
        issue(4'd1,  2'd0, 2'd2, 2'd1, 8'd0,   8'd156, 1'b0, 1'b0);
        issue(4'd15, 2'd3, 2'd0, 2'd0, 8'd20,  8'd20,  1'b0, 1'b0);
        issue(4'd15, 2'd0, 2'd0, 2'd0, 8'd13,  8'd13,  1'b0, 1'b0);
        issue(4'd2,  2'd0, 2'd3, 2'd0, 8'd0,   8'd4,   1'b0, 1'b0);
        issue(4'd5,  2'd3, 2'd1, 2'd2, 8'd0,   8'd55,  1'b0, 1'b0);
        issue(4'd15, 2'd0, 2'd0, 2'd0, 8'hF0,  8'hF0,  1'b0, 1'b0);
        issue(4'd15, 2'd3, 2'd0, 2'd0, 8'h3C,  8'h3C,  1'b0, 1'b0);
        issue(4'd8,  2'd0, 2'd0, 2'd3, 8'd0,   8'hCC,  1'b0, 1'b0);
        issue(4'd15, 2'd3, 2'd0, 2'd0, 8'd7,   8'd7,   1'b0, 1'b0);
        issue(4'd3,  2'd0, 2'd1, 2'd3, 8'd0,   8'd28,  1'b0, 1'b0);
        issue(4'd4,  2'd0, 2'd1, 2'd3, 8'd0,   8'd4,   1'b0, 1'b0);
        dbg(2'd1, 200);

        // Faults: divide/modulo by zero and an illegal opcode leave r0 at 4
        issue(4'd15, 2'd2, 2'd0, 2'd0, 8'd0,   8'd0,   1'b0, 1'b0);
        issue(4'd3,  2'd0, 2'd1, 2'd2, 8'd0,   8'd0,   1'b1, 1'b0);
        dbg(2'd0, 4);
        issue(4'd4,  2'd0, 2'd1, 2'd2, 8'd0,   8'd0,   1'b1, 1'b0);
        issue(4'd12, 2'd0, 2'd1, 2'd3, 8'd9,   8'd0,   1'b1, 1'b0);
        dbg(2'd0, 4);

        // Back-pressure: response held, requests ignored
        resp_ready = 1'b0;
        issue(4'd15, 2'd3, 2'd0, 2'd0, 8'd99,  8'd99,  1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            req_op = 4'd0; req_rd = 2'd2; req_rs1 = 2'd1; req_rs2 = 2'd1;
            req_valid = (c % 2 == 0);
            @(posedge clk); #1;
            chk("stall_resp_valid", int'(resp_valid), 1);
            chk("stall_resp_data", int'(resp_data), 99);
            chk("stall_resp_rd", int'(resp_rd), 3);
            chk("stall_req_ready", int'(req_ready), 0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_resp_valid", int'(resp_valid), 0);
        chk("release_req_ready", int'(req_ready), 1);
        repeat (2) @(posedge clk); #1;
        chk("ignored_req_no_resp", int'(resp_valid), 0);
        dbg(2'd2, 0);

        // Reset during EXEC abandons the op
        @(negedge clk);
        req_op = 4'd0; req_rd = 2'd3; req_rs1 = 2'd1; req_rs2 = 2'd1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_resp_valid", int'(resp_valid), 0);
        chk("midrst_req_ready", int'(req_ready), 1);
        dbg(2'd3, 0);
        dbg(2'd1, 0);
        repeat (2) @(posedge clk); #1;
        chk("midrst_no_resp", int'(resp_valid), 0);

        // Dependent chain through r1
        issue(4'd15, 2'd1, 2'd0, 2'd0, 8'd3,   8'd3,   1'b0, 1'b0);
        issue(4'd0,  2'd1, 2'd1, 2'd1, 8'd0,   8'd6,   1'b0, 1'b0);
        issue(4'd0,  2'd1, 2'd1, 2'd1, 8'd0,   8'd12,  1'b0, 1'b0);
        issue(4'd0,  2'd1, 2'd1, 2'd1, 8'd0,   8'd24,  1'b0, 1'b0);
        dbg(2'd1, 24);

        repeat (3) @(posedge clk); #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
